// File: rtl/led_status_driver_if.sv
// LED status bus: calculator / PS/2 event pulses in, LED values and per-bit write strobes out.
// master = event source and LED-stage observer, slave = led_status_driver.
interface led_status_driver_if;
    localparam int unsigned LED_W = 8;
    localparam int unsigned OP_W  = 3;

    logic              key_valid;
    logic              op_valid;
    logic [OP_W-1:0]   op_code;
    logic              err_pulse;
    logic              ovf_pulse;
    logic              flag_clr;
    logic              ram_we;
    logic              ram_re;
    logic [LED_W-1:0]  led_input;
    logic [LED_W-1:0]  leds_sel;
    logic              ram_led;

    modport master (
        output key_valid, op_valid, op_code, err_pulse, ovf_pulse, flag_clr, ram_we, ram_re,
        input  led_input, leds_sel, ram_led
    );

    modport slave (
        input  key_valid, op_valid, op_code, err_pulse, ovf_pulse, flag_clr, ram_we, ram_re,
        output led_input, leds_sel, ram_led
    );
endinterface

// File: rtl/led_status_driver.sv
// led_status_driver: turns one-cycle event pulses into stable LED levels (stretched activity,
// sticky error/overflow flags, error blink, operator code, heartbeat) and emits per-bit write
// strobes for the downstream LED register stage, which has no reset of its own.
// Optional feature macro: LED_HEARTBEAT_EN (defined: heartbeat on LED 7; undefined: LED 7 tied low).
module led_status_driver #(
    parameter int unsigned HB_DIV    = 50000000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned STRETCH   = 10000000,
    parameter int unsigned CW        = 26
) (
    input  logic               clk,
    input  logic               reset,
    led_status_driver_if.slave bus
);
    localparam int unsigned LED_W = 8;
    localparam int unsigned OP_W  = 3;

    // Elaboration guard: every counter must be able to hold its terminal value.
    if ((CW < 32) && ((HB_DIV > (32'd1 << CW)) || (BLINK_DIV > (32'd1 << CW)) ||
                      (STRETCH >= (32'd1 << CW)))) begin : g_cw_check
        $error("led_status_driver: CW too narrow for HB_DIV/BLINK_DIV/STRETCH");
    end

    logic [CW-1:0]    blink_cnt;
    logic [CW-1:0]    key_cnt;
    logic [CW-1:0]    ram_cnt;
    logic             err_f;
    logic             ovf_f;
    logic             ph;
    logic             init;
    logic [OP_W-1:0]  op_r;
    logic             hb_c;
    logic [LED_W-1:0] vis_c;

`ifdef LED_HEARTBEAT_EN
    logic [CW-1:0] hb_cnt;
    logic          hb;

    // Heartbeat divider: toggle hb every HB_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == CW'(HB_DIV - 1)) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + CW'(1);
        end
    end

    assign hb_c = hb;
`else
    assign hb_c = 1'b0;
`endif

    // Sticky flags; a set pulse wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_f <= 1'b0;
            ovf_f <= 1'b0;
        end else begin
            if (bus.err_pulse)     err_f <= 1'b1;
            else if (bus.flag_clr) err_f <= 1'b0;
            if (bus.ovf_pulse)     ovf_f <= 1'b1;
            else if (bus.flag_clr) ovf_f <= 1'b0;
        end
    end

    // Error blink; idles in the lit phase so a fresh error shows immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            ph        <= 1'b1;
        end else if (!err_f) begin
            blink_cnt <= '0;
            ph        <= 1'b1;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            ph        <= ~ph;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // Activity stretchers: reload on a pulse, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_cnt <= '0;
            ram_cnt <= '0;
        end else begin
            if (bus.key_valid)      key_cnt <= CW'(STRETCH);
            else if (key_cnt != '0) key_cnt <= key_cnt - CW'(1);
            if (bus.ram_we || bus.ram_re) ram_cnt <= CW'(STRETCH);
            else if (ram_cnt != '0)       ram_cnt <= ram_cnt - CW'(1);
        end
    end

    // Operator code capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            op_r <= '0;
        else if (bus.op_valid) op_r <= bus.op_code;
    end

    // Visible LED vector.
    always_comb begin
        vis_c      = '0;
        vis_c[7]   = hb_c;
        vis_c[6]   = err_f & ph;
        vis_c[5]   = ovf_f;
        vis_c[4]   = (key_cnt != '0);
        vis_c[3:1] = op_r;
        vis_c[0]   = (ram_cnt != '0);
    end

    // Output stage: strobe changed bits, and every bit once after reset to refresh the LED stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.led_input <= '0;
            bus.leds_sel  <= '0;
            bus.ram_led   <= 1'b0;
            init          <= 1'b1;
        end else begin
            bus.led_input <= vis_c;
            bus.ram_led   <= vis_c[0];
            bus.leds_sel  <= (vis_c ^ bus.led_input) | {LED_W{init}};
            init          <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_status_driver.sv
// Directed self-checking bench for led_status_driver with small dividers
// (HB_DIV=8, BLINK_DIV=2, STRETCH=4). Works with or without LED_HEARTBEAT_EN.
module tb_led_status_driver;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;

    led_status_driver_if bus();

    led_status_driver #(
        .HB_DIV    (8),
        .BLINK_DIV (2),
        .STRETCH   (4),
        .CW        (26)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       e7;
        logic       s7;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.key_valid = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'b000;
        bus.err_pulse = 1'b0;
        bus.ovf_pulse = 1'b0;
        bus.flag_clr  = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_re    = 1'b0;

        // Reset and post-reset refresh
        #3 reset = 1'b0;
        steps(2);
        check("rst_led", bus.led_input, 8'h00);
        check("rst_sel", bus.leds_sel, 8'h00);
        check("rst_ram", {7'b0, bus.ram_led}, 8'h00);
        reset = 1'b1;
        cyc = 0;
        step();
        check("refresh_sel", bus.leds_sel, 8'hFF);
        check("refresh_led", bus.led_input, 8'h00);

        // Heartbeat: LED 7 toggles every 8 cycles with a one-cycle strobe
        for (int n = 2; n <= 20; n++) begin
            step();
`ifdef LED_HEARTBEAT_EN
            e7 = 1'(((n - 1) / 8) % 2);
            s7 = ((n - 1) >= 8) && (((n - 1) % 8) == 0);
`else
            e7 = 1'b0;
            s7 = 1'b0;
`endif
            check("hb_led", bus.led_input, {e7, 7'b0});
            check("hb_sel", bus.leds_sel, {s7, 7'b0});
        end

        // Key stretch with retrigger
        bus.key_valid = 1'b1; step(); bus.key_valid = 1'b0;
        step();
        check("key_rise_led", bus.led_input & 8'h7F, 8'h10);
        check("key_rise_sel", bus.leds_sel & 8'h7F, 8'h10);
        steps(3);
        check("key_hold_led", bus.led_input & 8'h7F, 8'h10);
        check("key_hold_sel", bus.leds_sel & 8'h7F, 8'h00);
        step();
        check("key_fall_led", bus.led_input & 8'h7F, 8'h00);
        check("key_fall_sel", bus.leds_sel & 8'h7F, 8'h10);
        step();
        check("key_idle_sel", bus.leds_sel & 8'h7F, 8'h00);
        bus.key_valid = 1'b1; step(); bus.key_valid = 1'b0;
        step();
        bus.key_valid = 1'b1; step(); bus.key_valid = 1'b0;
        steps(4);
        check("key_retrig_hold", bus.led_input & 8'h7F, 8'h10);
        step();
        check("key_retrig_fall", bus.led_input & 8'h7F, 8'h00);
        check("key_retrig_sel", bus.leds_sel & 8'h7F, 8'h10);
        steps(2);

        // Operator code
        bus.op_code = 3'b010; bus.op_valid = 1'b1; step(); bus.op_valid = 1'b0;
        step();
        check("op010_led", bus.led_input & 8'h7F, 8'h04);
        check("op010_sel", bus.leds_sel & 8'h7F, 8'h04);
        bus.op_code = 3'b101; bus.op_valid = 1'b1; step(); bus.op_valid = 1'b0;
        step();
        check("op101_led", bus.led_input & 8'h7F, 8'h0A);
        check("op101_sel", bus.leds_sel & 8'h7F, 8'h0E);
        step();
        check("op_hold_sel", bus.leds_sel & 8'h7F, 8'h00);
        bus.op_valid = 1'b1; step(); bus.op_valid = 1'b0;
        step();
        check("op_same_led", bus.led_input & 8'h7F, 8'h0A);
        check("op_same_sel", bus.leds_sel & 8'h7F, 8'h00);

        // Error blink and sticky flag clear
        bus.err_pulse = 1'b1; step(); bus.err_pulse = 1'b0;
        step();
        check("blink_on_led", bus.led_input & 8'h7F, 8'h4A);
        check("blink_on_sel", bus.leds_sel & 8'h7F, 8'h40);
        step();
        check("blink_k2", {7'b0, bus.led_input[6]}, 8'h01);
        check("blink_k2_sel", bus.leds_sel & 8'h7F, 8'h00);
        step();
        check("blink_k3", {7'b0, bus.led_input[6]}, 8'h00);
        check("blink_k3_sel", bus.leds_sel & 8'h7F, 8'h40);
        step();
        check("blink_k4", {7'b0, bus.led_input[6]}, 8'h00);
        step();
        check("blink_k5", {7'b0, bus.led_input[6]}, 8'h01);
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
        check("clr_k6", {7'b0, bus.led_input[6]}, 8'h01);
        step();
        check("clr_off", {7'b0, bus.led_input[6]}, 8'h00);
        step();
        check("clr_stay", {7'b0, bus.led_input[6]}, 8'h00);
        check("clr_stay_sel", bus.leds_sel & 8'h7F, 8'h00);
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
        step();
        check("clr_idle_led", bus.led_input & 8'h7F, 8'h0A);
        check("clr_idle_sel", bus.leds_sel & 8'h7F, 8'h00);
        bus.err_pulse = 1'b1; bus.flag_clr = 1'b1; step();
        bus.err_pulse = 1'b0; bus.flag_clr = 1'b0;
        step();
        check("set_wins_led", {7'b0, bus.led_input[6]}, 8'h01);
        check("set_wins_sel", bus.leds_sel & 8'h7F, 8'h40);
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
        steps(3);
        check("err_cleared", {7'b0, bus.led_input[6]}, 8'h00);

        // RAM activity: read, then write two cycles later
        bus.ram_re = 1'b1; step(); bus.ram_re = 1'b0;
        step();
        bus.ram_we = 1'b1;
        check("ram_rise_led", {7'b0, bus.led_input[0]}, 8'h01);
        check("ram_rise_ramled", {7'b0, bus.ram_led}, 8'h01);
        check("ram_rise_sel", bus.leds_sel & 8'h7F, 8'h01);
        step(); bus.ram_we = 1'b0;
        check("ram_k2_sel", bus.leds_sel & 8'h7F, 8'h00);
        steps(4);
        check("ram_k6_led", {7'b0, bus.led_input[0]}, 8'h01);
        check("ram_k6_ramled", {7'b0, bus.ram_led}, 8'h01);
        check("ram_k6_sel", bus.leds_sel & 8'h7F, 8'h00);
        step();
        check("ram_fall_led", {7'b0, bus.led_input[0]}, 8'h00);
        check("ram_fall_ramled", {7'b0, bus.ram_led}, 8'h00);
        check("ram_fall_sel", bus.leds_sel & 8'h7F, 8'h01);
        steps(2);

        // Overflow, then reset mid-stretch
        bus.ovf_pulse = 1'b1; step(); bus.ovf_pulse = 1'b0;
        step();
        check("ovf_led", {7'b0, bus.led_input[5]}, 8'h01);
        check("ovf_sel", bus.leds_sel & 8'h7F, 8'h20);
        bus.key_valid = 1'b1; bus.ram_we = 1'b1; step();
        bus.key_valid = 1'b0; bus.ram_we = 1'b0;
        step();
        check("pre_rst_led", bus.led_input & 8'h7F, 8'h3B);
        check("pre_rst_ramled", {7'b0, bus.ram_led}, 8'h01);
        #2 reset = 1'b0;
        #1;
        check("async_rst_led", bus.led_input, 8'h00);
        check("async_rst_sel", bus.leds_sel, 8'h00);
        check("async_rst_ramled", {7'b0, bus.ram_led}, 8'h00);
        steps(2);
        reset = 1'b1;
        step();
        check("rerefresh_sel", bus.leds_sel, 8'hFF);
        check("rerefresh_led", bus.led_input, 8'h00);
        step();
        check("rerefresh_next_sel", bus.leds_sel, 8'h00);
        check("rerefresh_next_led", bus.led_input, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
